updown_bcd_counter_fnd: RTL and testbench
=========================================

UPDOWN_BCD_COUNTER_FND -- requirements
Module: updown_bcd_counter_fnd

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4, giving the number of BCD digits counted and displayed (legal range 1..4).
REQ-002 The module SHALL have parameter TICK_DIV, default 50_000_000, giving the clk cycles per count step.
REQ-003 The module SHALL have parameter SCAN_DIV, default 100_000, giving the clk cycles per display digit slot.
REQ-004 The module SHALL have parameter DB_CYC, default 1_000_000, giving the stable-level cycles required to accept a button change.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The module SHALL have ports btn_dir, btn_run and btn_clr, inputs, 1 bit each: raw asynchronous buttons (direction toggle, run/pause toggle, clear), active-high.
REQ-008 The module SHALL have port count_bcd, output, 4*DIGITS bits: the packed BCD count, with digit 0 at the LSBs.
REQ-009 The module SHALL have port dir, output, 1 bit: 1 = up, 0 = down.
REQ-010 The module SHALL have port run, output, 1 bit: 1 = counting, 0 = paused.
REQ-011 The module SHALL have ports carry and borrow, outputs, 1 bit each: single-cycle wrap pulses.
REQ-012 The module SHALL have port com, output, 4 bits: active-low digit enables.
REQ-013 The module SHALL have port seg_7, output, 8 bits: active-low segments ordered {dp,g,f,e,d,c,b,a}.

Function
REQ-014 Each button SHALL pass through a 2-FF synchroniser, then a debouncer that updates its level only after DB_CYC consecutive equal samples.
REQ-015 Each debouncer SHALL emit a 1-cycle pulse on the debounced rising edge, between DB_CYC and DB_CYC+3 cycles after the raw rising edge.
REQ-016 A raw pulse shorter than DB_CYC cycles SHALL produce no pulse.
REQ-017 A dir pulse SHALL toggle dir, and a run pulse SHALL toggle run.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only while run=1, assert tick for one cycle at TICK_DIV-1 and wrap to 0; it SHALL hold its value while paused.
REQ-019 On tick, count_bcd SHALL step ±1 in BCD per dir, with per-digit 9→0 and 0→9 propagation and no invalid nibbles ever.
REQ-020 An up step from the all-9s value SHALL give 0 with carry=1 in the same cycle as the count update; a down step from 0 SHALL give all-9s with borrow=1.
REQ-021 A clr pulse SHALL set count_bcd=0 and prescaler=0, and SHALL take priority over a coincident tick, with no carry or borrow.
REQ-022 A dir toggle coincident with a tick SHALL leave that tick using the old dir; the new dir applies from the next tick.
REQ-023 The scan index SHALL advance 0..DIGITS-1 cyclically every SCAN_DIV cycles.
REQ-024 com SHALL drive the active digit low; bits at DIGITS and above SHALL stay 1.
REQ-025 seg_7 SHALL show the active digit's hex-free 0-9 pattern, registered, aligned with com.
REQ-026 The dp segment SHALL be lit on digit 0 only when dir=0.

Reset
REQ-027 While reset_n=0 at a clk edge: count_bcd=0, dir=1, run=1, carry=borrow=0, prescaler=0, scan index=0, com=4'b1110, seg_7=8'hC0.
REQ-028 Reset SHALL clear synchroniser, debounce counters and debounced levels to 0, and SHALL take effect mid-count, mid-debounce and mid-scan alike.
REQ-029 A button held across reset release SHALL produce exactly one pulse, after DB_CYC cycles.

Structure
REQ-030 The 7-segment decode table, segment bit-order constants and the com idle value SHALL live in shared package fnd_pkg.
REQ-031 Synchroniser, debouncer and edge pulse SHALL form one sub-module, btn_cond (parameter DB_CYC), instantiated three times.
REQ-032 The BCD counter, prescaler and scan logic SHALL stay in the top module.

Verification (bench: DIGITS=2, TICK_DIV=4, SCAN_DIV=2, DB_CYC=3)
REQ-033 Bench SHALL cover: reset, run 99 ticks -> count_bcd=8'h99, next tick -> 8'h00 with one carry pulse.
REQ-034 Bench SHALL cover: at 8'h00 press btn_dir for 5 cycles -> dir=0; next tick -> 8'h99 with one borrow pulse, dp lit on digit 0.
REQ-035 Bench SHALL cover: btn_run glitch of 2 cycles -> run stays 1; a 5-cycle press -> run=0 and count frozen for 20 cycles.
REQ-036 Bench SHALL cover: clr pulse forced coincident with tick at 8'h99, dir=1 -> 8'h00, carry=0.
REQ-037 Bench SHALL cover: count 8'h07 -> com alternates 4'b1110/4'b1101 every 2 cycles; seg_7=8'hF8 with com=4'b1110 and 8'hC0 with com=4'b1101.
REQ-038 Bench SHALL cover: reset_n low 1 cycle mid-count with dir=0, run=0 -> all REQ-027 values on the next cycle.

Source files
------------

// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_pkg
//  Description : Shared constants and the 7-segment decode table for the
//                up/down BCD counter with multiplexed FND display.
//  Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    // Bit position of the decimal point inside seg_7 = {dp,g,f,e,d,c,b,a}
    localparam int SEG_DP = 7;

    // Digit-enable values (active-low): nothing selected / digit 0 selected
    localparam logic [3:0] COM_IDLE  = 4'b1111;
    localparam logic [3:0] COM_RESET = 4'b1110;

    // Segment value shown while in reset: digit "0", dp dark
    localparam logic [7:0] SEG_RESET = 8'hC0;

    // All seven segments dark (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit; non-decimal
    // codes blank the digit instead of showing a hex glyph.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_bcd_counter_fnd_if.sv
`default_nettype none
// ============================================================================
//  Module      : updown_bcd_counter_fnd_if
//  Description : Button conditioning link: raw button level in, one-cycle
//                debounced rising-edge pulse out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface updown_bcd_counter_fnd_if;

    logic raw;
    logic pulse;

    // Consumer side: supplies the raw button and receives the pulse
    modport master (output raw, input pulse);

    // Conditioner side
    modport slave  (input raw, output pulse);

endinterface
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : btn_cond
//  Description : Two-flop synchroniser, counting debouncer and rising-edge
//                pulse generator for one asynchronous push button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_cond #(
    parameter int DB_CYC = 1_000_000
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    updown_bcd_counter_fnd_if.slave     btn
);

    localparam int             CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounce: count consecutive samples that differ from the accepted
    // level; the level follows only after DB_CYC of them in a row.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            pulse_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, debounce state and pulse register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn.raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn.pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/updown_bcd_counter_fnd.sv
`default_nettype none
// ============================================================================
//  Module      : updown_bcd_counter_fnd
//  Description : Button-controlled up/down BCD counter with prescaler and a
//                multiplexed active-low 7-segment (FND) display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_bcd_counter_fnd
    import fnd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int DB_CYC   = 1_000_000
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  btn_dir,
    input  wire logic                  btn_run,
    input  wire logic                  btn_clr,
    output logic [4*DIGITS-1:0]        count_bcd,
    output logic                       dir,
    output logic                       run,
    output logic                       carry,
    output logic                       borrow,
    output logic [3:0]                 com,
    output logic [7:0]                 seg_7
);

    localparam int                 CNT_W      = 4 * DIGITS;
    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam int                 SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [1:0]         IDX_LAST   = 2'(DIGITS - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    updown_bcd_counter_fnd_if dir_btn_if ();
    updown_bcd_counter_fnd_if run_btn_if ();
    updown_bcd_counter_fnd_if clr_btn_if ();

    assign dir_btn_if.raw = btn_dir;
    assign run_btn_if.raw = btn_run;
    assign clr_btn_if.raw = btn_clr;

    btn_cond #(.DB_CYC(DB_CYC)) u_btn_dir (.clk(clk), .reset_n(reset_n), .btn(dir_btn_if));
    btn_cond #(.DB_CYC(DB_CYC)) u_btn_run (.clk(clk), .reset_n(reset_n), .btn(run_btn_if));
    btn_cond #(.DB_CYC(DB_CYC)) u_btn_clr (.clk(clk), .reset_n(reset_n), .btn(clr_btn_if));

    logic dir_pulse;
    logic run_pulse;
    logic clr_pulse;

    assign dir_pulse = dir_btn_if.pulse;
    assign run_pulse = run_btn_if.pulse;
    assign clr_pulse = clr_btn_if.pulse;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               dir_q,     dir_d;
    logic               run_q,     run_d;
    logic               carry_q,   carry_d;
    logic               borrow_q,  borrow_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         scan_idx_q, scan_idx_d;
    logic [3:0]         com_q,     com_d;
    logic [7:0]         seg_q,     seg_d;

    logic               tick;
    logic [CNT_W-1:0]   step_val;
    logic               step_wrap;
    logic [3:0]         digit_sel;

    // Prescaler: free-runs only while counting, tick on its last value
    always_comb begin
        tick    = run_q && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (clr_pulse) begin
            presc_d = '0;
        end else if (run_q) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // One BCD step in the current direction; step_wrap survives only if
    // every digit rolled over (9->0 going up, 0->9 going down).
    always_comb begin
        step_val  = count_q;
        step_wrap = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_wrap) begin
                if (dir_q) begin
                    if (step_val[i*4 +: 4] == 4'd9) begin
                        step_val[i*4 +: 4] = 4'd0;
                    end else begin
                        step_val[i*4 +: 4] = step_val[i*4 +: 4] + 4'd1;
                        step_wrap          = 1'b0;
                    end
                end else begin
                    if (step_val[i*4 +: 4] == 4'd0) begin
                        step_val[i*4 +: 4] = 4'd9;
                    end else begin
                        step_val[i*4 +: 4] = step_val[i*4 +: 4] - 4'd1;
                        step_wrap          = 1'b0;
                    end
                end
            end
        end
    end

    // Counter update: clear wins over a coincident tick; the tick always
    // uses the direction held before any same-cycle toggle.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        dir_d    = dir_pulse ? ~dir_q : dir_q;
        run_d    = run_pulse ? ~run_q : run_q;
        if (clr_pulse) begin
            count_d = '0;
        end else if (tick) begin
            count_d  = step_val;
            carry_d  = step_wrap &  dir_q;
            borrow_d = step_wrap & ~dir_q;
        end
    end

    // Scan slot timer and digit index
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? 2'd0 : scan_idx_q + 2'd1;
        end
    end

    // Display decode for the active slot; com and seg are registered
    // together so they always change on the same edge.
    always_comb begin
        digit_sel = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == 2'(i)) begin
                digit_sel = count_q[i*4 +: 4];
            end
        end
        com_d             = COM_IDLE;
        com_d[scan_idx_q] = 1'b0;
        seg_d             = {1'b1, seg_decode(digit_sel)};
        if ((scan_idx_q == 2'd0) && !dir_q) begin
            seg_d[SEG_DP] = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            dir_q      <= 1'b1;
            run_q      <= 1'b1;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            presc_q    <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= 2'd0;
            com_q      <= COM_RESET;
            seg_q      <= SEG_RESET;
        end else begin
            count_q    <= count_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            presc_q    <= presc_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            com_q      <= com_d;
            seg_q      <= seg_d;
        end
    end

    assign count_bcd = count_q;
    assign dir       = dir_q;
    assign run       = run_q;
    assign carry     = carry_q;
    assign borrow    = borrow_q;
    assign com       = com_q;
    assign seg_7     = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_bcd_counter_fnd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_bcd_counter_fnd
//  Description : Self-checking bench for updown_bcd_counter_fnd with
//                DIGITS=2, TICK_DIV=4, SCAN_DIV=2, DB_CYC=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_bcd_counter_fnd;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int DB_CYC   = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_dir;
    logic       btn_run;
    logic       btn_clr;
    logic [7:0] count_bcd;
    logic       dir;
    logic       run;
    logic       carry;
    logic       borrow;
    logic [3:0] com;
    logic [7:0] seg_7;

    typedef struct {
        int         cycles;
        logic [7:0] exp_count;
    } vec_t;

    vec_t       vecs [4];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_carry  = 0;
    int         n_borrow = 0;
    int         carry_snap;
    logic [7:0] count_snap;
    logic [3:0] com_a;
    logic [3:0] com_b;
    logic [3:0] com_hist [8];

    updown_bcd_counter_fnd #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .DB_CYC   (DB_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_dir   (btn_dir),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .count_bcd (count_bcd),
        .dir       (dir),
        .run       (run),
        .carry     (carry),
        .borrow    (borrow),
        .com       (com),
        .seg_7     (seg_7)
    );

    always #5 clk = ~clk;

    // Count wrap pulses just after each edge that can produce them
    always @(posedge clk) begin
        #1;
        if (carry === 1'b1)  n_carry++;
        if (borrow === 1'b1) n_borrow++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Check the segment output against the slot currently enabled
    task automatic check_slot(input string name, input logic [7:0] exp0,
                              input logic [7:0] exp1, output logic [3:0] seen);
        seen = com;
        if (com == 4'b1110) begin
            check({name, "_d0"}, {24'd0, seg_7}, {24'd0, exp0});
        end else begin
            check({name, "_com"}, {28'd0, com}, 32'h0000_000D);
            check({name, "_d1"}, {24'd0, seg_7}, {24'd0, exp1});
        end
    endtask

    initial begin
        // cycles to advance from the previous point, expected count after
        vecs[0] = '{4,   8'h01};
        vecs[1] = '{32,  8'h09};
        vecs[2] = '{4,   8'h10};
        vecs[3] = '{356, 8'h99};

        reset_n = 1'b0;
        btn_dir = 1'b0;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        cyc(3);
        check("rst_count",  {24'd0, count_bcd}, 32'h00);
        check("rst_dir",    {31'd0, dir},       32'h1);
        check("rst_run",    {31'd0, run},       32'h1);
        check("rst_carry",  {31'd0, carry},     32'h0);
        check("rst_borrow", {31'd0, borrow},    32'h0);
        check("rst_com",    {28'd0, com},       32'hE);
        check("rst_seg",    {24'd0, seg_7},     32'hC0);
        reset_n = 1'b1;

        // Count up 0 -> 99, one step every 4 cycles
        for (int v = 0; v < 4; v++) begin
            cyc(vecs[v].cycles);
            check($sformatf("up_vec%0d", v), {24'd0, count_bcd}, {24'd0, vecs[v].exp_count});
        end
        check("no_carry_before_wrap", n_carry, 0);

        // 99 -> 00 with carry, then direction press takes effect before the next tick
        btn_dir = 1'b1;
        cyc(4);
        check("wrap_up_count", {24'd0, count_bcd}, 32'h00);
        check("wrap_up_carry", {31'd0, carry},     32'h1);
        cyc(1);
        btn_dir = 1'b0;
        cyc(1);
        check("dir_toggled", {31'd0, dir}, 32'h0);
        cyc(2);
        check("wrap_dn_count",  {24'd0, count_bcd}, 32'h99);
        check("wrap_dn_borrow", {31'd0, borrow},    32'h1);
        check("carry_pulses",  n_carry,  1);
        check("borrow_pulses", n_borrow, 1);
        cyc(1);
        check_slot("dp_slot_a", 8'h10, 8'h90, com_a);
        cyc(2);
        check_slot("dp_slot_b", 8'h10, 8'h90, com_b);
        check("dp_slots_differ", {31'd0, com_a != com_b}, 32'h1);

        // Short glitch on run is ignored; a real press pauses
        btn_run = 1'b1;
        cyc(2);
        btn_run = 1'b0;
        cyc(8);
        check("glitch_run", {31'd0, run}, 32'h1);
        btn_run = 1'b1;
        cyc(5);
        btn_run = 1'b0;
        cyc(1);
        check("paused_run", {31'd0, run}, 32'h0);
        count_snap = count_bcd;
        cyc(20);
        check("frozen_count", {24'd0, count_bcd}, {24'd0, count_snap});
        check("still_paused", {31'd0, run}, 32'h0);

        // Clear while paused
        btn_clr = 1'b1;
        cyc(5);
        btn_clr = 1'b0;
        cyc(1);
        check("clr_paused", {24'd0, count_bcd}, 32'h00);
        cyc(6);

        // Resume, step down to 99, flip to up, clear lands on the wrapping tick
        btn_run = 1'b1;
        cyc(5);
        btn_run = 1'b0;
        cyc(1);
        btn_dir = 1'b1;
        check("resumed", {31'd0, run}, 32'h1);
        cyc(2);
        btn_clr = 1'b1;
        cyc(2);
        check("pre_clr_count",  {24'd0, count_bcd}, 32'h99);
        check("pre_clr_borrow", {31'd0, borrow},    32'h1);
        cyc(1);
        btn_dir = 1'b0;
        cyc(1);
        check("pre_clr_dir", {31'd0, dir}, 32'h1);
        carry_snap = n_carry;
        cyc(1);
        btn_clr = 1'b0;
        cyc(1);
        check("clr_tick_count", {24'd0, count_bcd}, 32'h00);
        check("clr_tick_carry", {31'd0, carry},     32'h0);
        cyc(2);
        check("clr_no_carry_pulse", n_carry, carry_snap);

        // Count to 07 and pause exactly there
        cyc(21);
        btn_run = 1'b1;
        cyc(5);
        btn_run = 1'b0;
        check("count_07", {24'd0, count_bcd}, 32'h07);
        cyc(1);
        check("paused_at_07", {31'd0, run}, 32'h0);
        cyc(8);
        check("hold_07", {24'd0, count_bcd}, 32'h07);

        // Scan: two cycles per slot, F8 on digit 0, C0 on digit 1
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check_slot($sformatf("scan%0d", k), 8'hF8, 8'hC0, com_hist[k]);
            if (k >= 2) begin
                check($sformatf("scan_period%0d", k), {31'd0, com_hist[k] != com_hist[k-2]}, 32'h1);
            end
        end

        // Set dir=0 while paused, then reset mid-debounce with run held
        btn_dir = 1'b1;
        cyc(5);
        btn_dir = 1'b0;
        cyc(1);
        check("dir_down_paused", {31'd0, dir}, 32'h0);
        cyc(4);
        btn_run = 1'b1;
        cyc(3);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        check("mid_rst_count",  {24'd0, count_bcd}, 32'h00);
        check("mid_rst_dir",    {31'd0, dir},       32'h1);
        check("mid_rst_run",    {31'd0, run},       32'h1);
        check("mid_rst_carry",  {31'd0, carry},     32'h0);
        check("mid_rst_borrow", {31'd0, borrow},    32'h0);
        check("mid_rst_com",    {28'd0, com},       32'hE);
        check("mid_rst_seg",    {24'd0, seg_7},     32'hC0);
        cyc(5);
        check("held_btn_not_early", {31'd0, run}, 32'h1);
        cyc(1);
        check("held_btn_one_pulse", {31'd0, run}, 32'h0);
        cyc(12);
        check("held_btn_no_repeat", {31'd0, run}, 32'h0);
        btn_run = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
